// File: rtl/dk_anim_pkg.sv
// Shared types and default frame counts
// for the Donkey Kong animation sequencer.
package dk_anim_pkg;

  localparam int FW                 = 19;
  localparam int DEF_FRAME_DIV      = 4;
  localparam int DEF_IDLE_FRAMES    = 8;
  localparam int DEF_WALK_FRAMES    = 20;
  localparam int DEF_JUMP_FRAMES    = 12;
  localparam int DEF_SPECIAL_FRAMES = 10;
  localparam int DEF_CANDY_FRAMES   = 6;
  localparam int DEF_CANDY_DIV      = 2;

  typedef enum logic [3:0] {
    M_IDLE_R  = 4'd0,
    M_IDLE_L  = 4'd1,
    M_WALK_R  = 4'd2,
    M_WALK_L  = 4'd3,
    M_JUMP_R  = 4'd4,
    M_JUMP_L  = 4'd5,
    M_SPECIAL = 4'd6
  } motion_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK,
    S_JUMP,
    S_SPECIAL
  } state_t;

  // Special ignores facing; the others add it.
  function automatic motion_t motion_of(
    input state_t s,
    input logic   left
  );
    motion_t m;
    m = M_IDLE_R;
    unique case (s)
      S_IDLE:    m = left ? M_IDLE_L : M_IDLE_R;
      S_WALK:    m = left ? M_WALK_L : M_WALK_R;
      S_JUMP:    m = left ? M_JUMP_L : M_JUMP_R;
      S_SPECIAL: m = M_SPECIAL;
      default:   m = M_IDLE_R;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dk_anim_frame_counter.sv
// Divided frame counter: advances idx every DIV
// ticks, wrapping at len-1; clear wins over tick.
module dk_anim_frame_counter #(
  parameter int DIV = 4,
  parameter int W   = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         clear,
  input  logic [W-1:0] len,
  output logic [W-1:0] idx,
  output logic         wrap
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [W-1:0]  idx_q, idx_d;
  logic          last_div;
  logic          last_idx;

  assign last_div = (div_q == DIV_MAX);
  assign last_idx = (idx_q == len - W'(1));
  assign wrap     = tick & last_div & last_idx;
  assign idx      = idx_q;

  // Next divider/index: clear, else step on tick.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (clear) begin
      div_d = '0;
      idx_d = '0;
    end else if (tick) begin
      if (last_div) begin
        div_d = '0;
        idx_d = last_idx ? '0 : idx_q + W'(1);
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/dk_anim_sequencer.sv
// Sprite animation sequencer: movement requests
// to motion code, body frame and candy frame.
module dk_anim_sequencer
  import dk_anim_pkg::*;
#(
  parameter int FRAME_DIV      = DEF_FRAME_DIV,
  parameter int IDLE_FRAMES    = DEF_IDLE_FRAMES,
  parameter int WALK_FRAMES    = DEF_WALK_FRAMES,
  parameter int JUMP_FRAMES    = DEF_JUMP_FRAMES,
  parameter int SPECIAL_FRAMES = DEF_SPECIAL_FRAMES,
  parameter int CANDY_FRAMES   = DEF_CANDY_FRAMES,
  parameter int CANDY_DIV      = DEF_CANDY_DIV
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_clk,
  input  logic          req_left,
  input  logic          req_right,
  input  logic          req_jump,
  input  logic          req_special,
  output logic [3:0]    motion,
  output logic [FW-1:0] framenum,
  output logic [FW-1:0] candy_frame,
  output logic          facing_left,
  output logic          busy,
  output logic          anim_done
);

  logic          frame_clk_q;
  logic          tick;
  state_t        state_q, state_d;
  logic          facing_q, facing_d;
  motion_t       motion_q, motion_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          walk_l, walk_r;
  logic          body_clear;
  logic [FW-1:0] body_len;
  logic          body_wrap;
  logic          candy_tick;
  logic          candy_clear;
  logic          candy_wrap_unused;

  assign tick   = frame_clk & ~frame_clk_q;
  assign walk_l = req_left & ~req_right;
  assign walk_r = req_right & ~req_left;

  // Loop/one-shot length of the current state.
  always_comb begin
    body_len = FW'(IDLE_FRAMES);
    unique case (state_q)
      S_IDLE:    body_len = FW'(IDLE_FRAMES);
      S_WALK:    body_len = FW'(WALK_FRAMES);
      S_JUMP:    body_len = FW'(JUMP_FRAMES);
      S_SPECIAL: body_len = FW'(SPECIAL_FRAMES);
      default:   body_len = FW'(IDLE_FRAMES);
    endcase
  end

  // Next state: one-shots run to completion,
  // otherwise special > jump > walk > idle.
  always_comb begin
    state_d    = state_q;
    facing_d   = facing_q;
    body_clear = 1'b0;
    done_d     = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_JUMP, S_SPECIAL: begin
          if (body_wrap) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          if (req_special) begin
            state_d    = S_SPECIAL;
            body_clear = 1'b1;
          end else if (req_jump) begin
            state_d    = S_JUMP;
            body_clear = 1'b1;
          end else if (walk_l | walk_r) begin
            if (state_q != S_WALK ||
                walk_l != facing_q) begin
              state_d    = S_WALK;
              facing_d   = walk_l;
              body_clear = 1'b1;
            end
          end else if (state_q != S_IDLE) begin
            state_d    = S_IDLE;
            body_clear = 1'b1;
          end
        end
      endcase
    end
  end

  assign candy_tick  = tick & (state_q == S_SPECIAL);
  assign candy_clear = (state_q != S_SPECIAL) |
                       (state_d != S_SPECIAL);
  assign busy_d      = (state_d == S_JUMP) |
                       (state_d == S_SPECIAL);
  assign motion_d    = motion_of(state_d, facing_d);

  dk_anim_frame_counter #(
    .DIV (FRAME_DIV),
    .W   (FW)
  ) u_body (
    .clk   (Clk),
    .rst   (Reset),
    .tick  (tick),
    .clear (body_clear),
    .len   (body_len),
    .idx   (framenum),
    .wrap  (body_wrap)
  );

  dk_anim_frame_counter #(
    .DIV (CANDY_DIV),
    .W   (FW)
  ) u_candy (
    .clk   (Clk),
    .rst   (Reset),
    .tick  (candy_tick),
    .clear (candy_clear),
    .len   (FW'(CANDY_FRAMES)),
    .idx   (candy_frame),
    .wrap  (candy_wrap_unused)
  );

  // FSM state and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_clk_q <= 1'b0;
      state_q     <= S_IDLE;
      facing_q    <= 1'b0;
      motion_q    <= M_IDLE_R;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      frame_clk_q <= frame_clk;
      state_q     <= state_d;
      facing_q    <= facing_d;
      motion_q    <= motion_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign motion      = motion_q;
  assign facing_left = facing_q;
  assign busy        = busy_q;
  assign anim_done   = done_q;

endmodule

// File: tb/tb_dk_anim_sequencer.sv
// Scoreboard bench for dk_anim_sequencer:
// a behavioural model queues expected outputs per tick.
module tb_dk_anim_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic        req_left = 1'b0;
  logic        req_right = 1'b0;
  logic        req_jump = 1'b0;
  logic        req_special = 1'b0;
  logic [3:0]  motion;
  logic [18:0] framenum;
  logic [18:0] candy_frame;
  logic        facing_left;
  logic        busy;
  logic        anim_done;

  always #5 Clk = ~Clk;

  dk_anim_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .req_left    (req_left),
    .req_right   (req_right),
    .req_jump    (req_jump),
    .req_special (req_special),
    .motion      (motion),
    .framenum    (framenum),
    .candy_frame (candy_frame),
    .facing_left (facing_left),
    .busy        (busy),
    .anim_done   (anim_done)
  );

  typedef struct packed {
    logic [3:0]  mo;
    logic [18:0] fn;
    logic [18:0] cf;
    logic        face;
    logic        busy;
    logic        done;
  } obs_t;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // model state: st 0 idle, 1 walk, 2 jump, 3 special
  int   m_st, m_fn, m_div, m_cf, m_cdiv;
  bit   m_face;

  function automatic obs_t sample();
    obs_t o;
    o.mo   = motion;
    o.fn   = framenum;
    o.cf   = candy_frame;
    o.face = facing_left;
    o.busy = busy;
    o.done = anim_done;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("mo=%0d fn=%0d cf=%0d face=%0b busy=%0b done=%0b",
                     o.mo, o.fn, o.cf, o.face, o.busy, o.done);
  endfunction

  task automatic model_reset();
    m_st = 0; m_fn = 0; m_div = 0;
    m_cf = 0; m_cdiv = 0; m_face = 0;
  endtask

  task automatic model_tick();
    obs_t e;
    bit wl, wr, d;
    int ns, len;
    wl = req_left && !req_right;
    wr = req_right && !req_left;
    d = 0;
    if (m_st >= 2) begin
      len = (m_st == 2) ? 12 : 10;
      if (m_st == 3) begin
        m_cdiv++;
        if (m_cdiv == 2) begin
          m_cdiv = 0;
          m_cf = (m_cf + 1) % 6;
        end
      end
      m_div++;
      if (m_div == 4) begin
        m_div = 0;
        m_fn++;
        if (m_fn == len) begin
          m_st = 0; m_fn = 0; m_cf = 0; m_cdiv = 0; d = 1;
        end
      end
    end else begin
      ns = req_special ? 3 : req_jump ? 2 : (wl || wr) ? 1 : 0;
      if (ns != m_st || (ns == 1 && wl != m_face)) begin
        m_st = ns; m_fn = 0; m_div = 0; m_cf = 0; m_cdiv = 0;
        if (ns == 1) m_face = wl;
      end else begin
        m_div++;
        if (m_div == 4) begin
          m_div = 0;
          m_fn = (m_fn + 1) % ((m_st == 1) ? 20 : 8);
        end
      end
    end
    e.mo   = (m_st == 3) ? 4'd6 : 4'(m_st * 2 + int'(m_face));
    e.fn   = 19'(m_fn);
    e.cf   = 19'(m_cf);
    e.face = m_face;
    e.busy = (m_st >= 2);
    e.done = d;
    sb.push_back(e);
  endtask

  task automatic tick_once();
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
  endtask

  task automatic step();
    model_tick();
    tick_once();
  endtask

  task automatic test_reset();
    obs_t got;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    got = sample();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset: got %s want all zero", fmt(got));
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    obs_t got, exp;
    for (int i = 1; i <= 40; i++) begin
      step();
      exp = sb.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL idle[%0d]: got %s want %s", i, fmt(got), fmt(exp));
      end
      if (i == 31) begin
        checks++;
        if (framenum !== 19'd7) begin
          errors++;
          $display("FAIL idle_fn7: got %0d want 7", framenum);
        end
      end
      if (i == 32) begin
        checks++;
        if (framenum !== 19'd0) begin
          errors++;
          $display("FAIL idle_wrap: got %0d want 0", framenum);
        end
      end
    end
  endtask

  task automatic test_walk();
    obs_t got, exp;
    bit saw19, wrapped;
    saw19 = 0;
    wrapped = 0;
    req_right = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      exp = sb.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL walk_r[%0d]: got %s want %s", i, fmt(got), fmt(exp));
      end
      if (saw19 && framenum == 19'd0) wrapped = 1;
      if (framenum == 19'd19) saw19 = 1;
    end
    checks++;
    if (!(saw19 && wrapped)) begin
      errors++;
      $display("FAIL walk_wrap: got saw19=%0b wrapped=%0b want 1 1", saw19, wrapped);
    end
    req_right = 1'b0;
    req_left = 1'b1;
    step();
    exp = sb.pop_front();
    got = sample();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reversal: got %s want %s", fmt(got), fmt(exp));
    end
    checks++;
    if (motion !== 4'd3 || framenum !== 19'd0 || facing_left !== 1'b1) begin
      errors++;
      $display("FAIL reversal_const: got %s want mo=3 fn=0 face=1", fmt(got));
    end
    for (int i = 0; i < 5; i++) begin
      step();
      exp = sb.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL walk_l[%0d]: got %s want %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_jump();
    obs_t got, exp;
    int busy_cnt, done_cnt, jump_cnt;
    req_left = 1'b0;
    req_jump = 1'b1;
    step();
    exp = sb.pop_front();
    got = sample();
    checks++;
    if (got !== exp || motion !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL jump_entry: got %s want %s (mo=5)", fmt(got), fmt(exp));
    end
    req_jump = 1'b0;
    req_special = 1'b1;
    busy_cnt = 1;
    jump_cnt = 1;
    done_cnt = 0;
    for (int i = 1; i <= 48; i++) begin
      step();
      exp = sb.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL jump[%0d]: got %s want %s", i, fmt(got), fmt(exp));
      end
      if (busy) busy_cnt++;
      if (motion == 4'd5) jump_cnt++;
      if (anim_done) done_cnt++;
    end
    checks++;
    if (busy_cnt != 48 || jump_cnt != 48 || done_cnt != 1) begin
      errors++;
      $display("FAIL jump_len: got busy=%0d jump=%0d done=%0d want 48 48 1",
               busy_cnt, jump_cnt, done_cnt);
    end
    checks++;
    if (motion !== 4'd1 || framenum !== 19'd0 || anim_done !== 1'b1) begin
      errors++;
      $display("FAIL jump_end: got mo=%0d fn=%0d done=%0b want 1 0 1",
               motion, framenum, anim_done);
    end
    @(negedge Clk);
    checks++;
    if (anim_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got %0b want 0", anim_done);
    end
  endtask

  task automatic test_special();
    obs_t got, exp;
    step();
    exp = sb.pop_front();
    got = sample();
    checks++;
    if (got !== exp || motion !== 4'd6 || candy_frame !== 19'd0) begin
      errors++;
      $display("FAIL special_entry: got %s want %s", fmt(got), fmt(exp));
    end
    for (int i = 1; i <= 40; i++) begin
      step();
      exp = sb.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL special[%0d]: got %s want %s", i, fmt(got), fmt(exp));
      end
      if (i == 10) begin
        checks++;
        if (candy_frame !== 19'd5) begin
          errors++;
          $display("FAIL candy5: got %0d want 5", candy_frame);
        end
      end
      if (i == 12) begin
        checks++;
        if (candy_frame !== 19'd0) begin
          errors++;
          $display("FAIL candy_wrap: got %0d want 0", candy_frame);
        end
      end
    end
    checks++;
    if (motion !== 4'd1 || candy_frame !== 19'd0 || anim_done !== 1'b1) begin
      errors++;
      $display("FAIL special_end: got mo=%0d cf=%0d done=%0b want 1 0 1",
               motion, candy_frame, anim_done);
    end
    step();
    exp = sb.pop_front();
    got = sample();
    checks++;
    if (got !== exp || motion !== 4'd6) begin
      errors++;
      $display("FAIL special_reenter: got %s want %s", fmt(got), fmt(exp));
    end
    req_special = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      exp = sb.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL special2[%0d]: got %s want %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_conflict();
    obs_t got, exp;
    req_left = 1'b1;
    req_right = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp = sb.pop_front();
      got = sample();
      checks++;
      if (got !== exp || motion !== 4'd1) begin
        errors++;
        $display("FAIL lr_both[%0d]: got %s want %s", i, fmt(got), fmt(exp));
      end
    end
    req_left = 1'b0;
    req_right = 1'b0;
    req_jump = 1'b1;
    req_special = 1'b1;
    step();
    exp = sb.pop_front();
    got = sample();
    checks++;
    if (got !== exp || motion !== 4'd6) begin
      errors++;
      $display("FAIL jump_vs_special: got %s want %s", fmt(got), fmt(exp));
    end
    req_jump = 1'b0;
    req_special = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      exp = sb.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL conflict_tail[%0d]: got %s want %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_reset_mid_jump();
    obs_t got, exp;
    int done_seen;
    req_jump = 1'b1;
    step();
    exp = sb.pop_front();
    got = sample();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rj_entry: got %s want %s", fmt(got), fmt(exp));
    end
    req_jump = 1'b0;
    for (int i = 0; i < 28; i++) begin
      step();
      exp = sb.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rj[%0d]: got %s want %s", i, fmt(got), fmt(exp));
      end
    end
    checks++;
    if (framenum !== 19'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rj_fn7: got fn=%0d busy=%0b want 7 1", framenum, busy);
    end
    #2;
    Reset = 1'b1;
    #1;
    got = sample();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL async_reset: got %s want all zero", fmt(got));
    end
    done_seen = 0;
    repeat (3) begin
      @(negedge Clk);
      if (anim_done) done_seen++;
    end
    Reset = 1'b0;
    model_reset();
    repeat (4) begin
      @(negedge Clk);
      if (anim_done) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d pulses want 0", done_seen);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      exp = sb.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %s want %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_walk();
    test_jump();
    test_special();
    test_conflict();
    test_reset_mid_jump();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
